ccu_issue_ctrl: RTL
===================

Name: ccu_issue_ctrl

Overview:
- Issue/collect stage directly upstream of the CalculateUnit in the execute stage.
- Accepts one operation at a time from the ID/EX register through a valid/ready handshake and drives the CalculateUnit's number1, number2 and mode.
- Waits the required latency for multi-cycle (MUL/DIV, mode 8'h4x) results, then captures fast_answer or slow_answer plus the error code into a one-entry output register offered to writeback over a valid/ready handshake.
- Provides the pipeline stall signal and a sticky error register.

Parameters:
- SLOW_LAT, 1: number of clock edges after acceptance before slow_answer is captured; legal range 1..15.
- TAG_W, 5: width of the destination tag carried alongside the operation (rd index).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  synchronous reset, active low.
- in_valid  in  1  upstream operation valid.
- in_ready  out  1  block can accept an operation this cycle.
- in_num1  in  32  operand 1.
- in_num2  in  32  operand 2.
- in_mode  in  8  CalculateUnit mode code.
- in_tag  in  TAG_W  destination tag.
- flush  in  1  discard any in-flight operation and the buffered result.
- cu_number1  out  32  to CalculateUnit number1.
- cu_number2  out  32  to CalculateUnit number2.
- cu_mode  out  8  to CalculateUnit mode.
- cu_fast_answer  in  32  from CalculateUnit fast_answer.
- cu_slow_answer  in  32  from CalculateUnit slow_answer.
- cu_error  in  4  from CalculateUnit error (0 none, 1 no instruction, 2 divide by zero).
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  downstream consumes the result this cycle.
- res_data  out  32  result value.
- res_tag  out  TAG_W  tag of the result.
- res_err  out  4  error code captured with the result.
- stall  out  1  equals in_valid & ~in_ready.
- err_sticky  out  4  first non-zero res_err since reset or the last err_clr.
- err_clr  in  1  clears err_sticky.

Behaviour:
- Slow op: in_mode[7:4] == 4'h4. Every other mode is a fast op.
- State machine states: IDLE, WAIT. Internal registers: held num1, num2, mode and tag; a 4-bit countdown counter.
- CalculateUnit drive:
  - In IDLE, cu_* equal in_* combinationally.
  - In WAIT, cu_* equal the held registers, so the registered MDU keeps recomputing the same operands.
- out_free = ~res_valid | res_ready.
- in_ready = (state == IDLE) & out_free & ~flush. Acceptance is in_valid & in_ready.
- Fast accept:
  - At the accepting edge, load res_data <= cu_fast_answer, res_err <= cu_error, res_tag <= in_tag, res_valid <= 1.
  - Latency is 1 cycle. Back-to-back fast ops sustain 1 per cycle while res_ready is held high.
- Slow accept:
  - At the accepting edge, load the held registers and counter <= SLOW_LAT-1, then go to WAIT. res_valid clears at this edge if it was consumed.
- WAIT:
  - Decrement the counter each edge while counter != 0.
  - When counter == 0 and out_free: capture res_data <= cu_slow_answer, res_err <= cu_error, res_tag <= held tag, set res_valid, return to IDLE.
  - When counter == 0 and not out_free: remain in WAIT holding the operands; capture on the first edge where out_free holds.
- Slow latency: res_valid rises at edge E+SLOW_LAT for acceptance at edge E, when unblocked.
- Consumption: res_valid & res_ready with no new capture on the same edge clears res_valid. Capture and consumption on the same edge leaves res_valid = 1 holding the new data.
- Fast/slow interlock: no new op is accepted while in WAIT.
- err_sticky:
  - Loads res_err-to-be on a capture edge only when err_sticky == 0 and the captured error != 0.
  - err_clr clears it and takes priority over a simultaneous load.
- Flush:
  - Forces IDLE, clears res_valid and counter, and blocks acceptance in that cycle.
  - Does not affect err_sticky.
- Reset (rstn == 0 at an edge, including mid-WAIT):
  - State IDLE; res_valid 0; res_data 0; res_err 0; res_tag 0; err_sticky 0; counter 0; held registers 0.
- Held registers and res_data are don't-care when invalid but must never be X after reset.

Test Plan:
- ADD: in_mode 8'h01, in_num1 5, in_num2 7, res_ready 1 -> in_ready 1; one cycle later res_valid 1, res_data 12, res_err 0.
- DIVU with SLOW_LAT=1: in_mode 8'h45, in_num1 100, in_num2 7, in_tag 3 -> in_ready 0 for one cycle, stall asserted if in_valid is held; at edge E+1 res_valid 1, res_data 14, res_tag 3.
- DIV with in_num2 0: in_mode 8'h44 -> res_err 2, err_sticky 2; a following ADD leaves err_sticky 2; err_clr then gives err_sticky 0.
- Backpressure: res_ready 0 with a fast result held, then a new valid op -> in_ready 0 and res_data unchanged; set res_ready 1 -> new op accepted and next result present the cycle after.
- Slow op completes while output is full (res_ready 0) -> block stays in WAIT with cu_* equal to the held operands; raising res_ready captures on that edge and res_valid stays 1 with the new data.
- Flush in WAIT, and rstn low in WAIT -> both return to IDLE with res_valid 0 and in_ready 1 on the next cycle; reset additionally zeroes err_sticky and res_data.

Source files
------------

// File: rtl/ccu_issue_ctrl.sv
// Issue/collect stage in front of the CalculateUnit: accepts one operation, drives the unit,
// waits out multi-cycle MUL/DIV latency and buffers the result for writeback.
module ccu_issue_ctrl #(
    parameter int unsigned SLOW_LAT = 1,
    parameter int unsigned TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_num1,
    input  logic [31:0]      in_num2,
    input  logic [7:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic [31:0]      cu_number1,
    output logic [31:0]      cu_number2,
    output logic [7:0]       cu_mode,
    input  logic [31:0]      cu_fast_answer,
    input  logic [31:0]      cu_slow_answer,
    input  logic [3:0]       cu_error,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic [3:0]       res_err,
    output logic             stall,
    output logic [3:0]       err_sticky,
    input  logic             err_clr
);

    localparam int unsigned DW = 32;
    localparam int unsigned MW = 8;
    localparam int unsigned EW = 4;
    localparam int unsigned CW = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    held_num1, held_num2;
    logic [MW-1:0]    held_mode;
    logic [TAG_W-1:0] held_tag;

    logic             out_free;
    logic             accept;
    logic             slow_in;
    logic             load_hold;
    logic             fast_cap;
    logic             slow_cap;
    logic             capture;
    logic [DW-1:0]    cap_data;
    logic [TAG_W-1:0] cap_tag;

    // Next-state, handshake and CalculateUnit drive
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_hold  = 1'b0;
        slow_cap   = 1'b0;
        cu_number1 = in_num1;
        cu_number2 = in_num2;
        cu_mode    = in_mode;

        out_free = ~res_valid | res_ready;
        in_ready = (state_q == IDLE) & out_free & ~flush;
        accept   = in_valid & in_ready;
        slow_in  = (in_mode[7:4] == 4'h4);
        fast_cap = accept & ~slow_in;
        stall    = in_valid & ~in_ready;

        case (state_q)
            IDLE: begin
                if (accept && slow_in) begin
                    state_d   = WAIT;
                    cnt_d     = CW'(SLOW_LAT - 1);
                    load_hold = 1'b1;
                end
            end
            WAIT: begin
                // Keep the registered MDU recomputing the same operands until capture.
                cu_number1 = held_num1;
                cu_number2 = held_num2;
                cu_mode    = held_mode;
                if (cnt_q != CW'(0)) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (out_free) begin
                    slow_cap = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d   = IDLE;
            cnt_d     = CW'(0);
            load_hold = 1'b0;
            slow_cap  = 1'b0;
        end

        capture  = fast_cap | slow_cap;
        cap_data = fast_cap ? cu_fast_answer : cu_slow_answer;
        cap_tag  = fast_cap ? in_tag : held_tag;
    end

    // State and countdown register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= CW'(0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Held operands, result register and sticky error
    always_ff @(posedge clk) begin
        if (!rstn) begin
            held_num1  <= DW'(0);
            held_num2  <= DW'(0);
            held_mode  <= MW'(0);
            held_tag   <= TAG_W'(0);
            res_valid  <= 1'b0;
            res_data   <= DW'(0);
            res_tag    <= TAG_W'(0);
            res_err    <= EW'(0);
            err_sticky <= EW'(0);
        end else begin
            if (load_hold) begin
                held_num1 <= in_num1;
                held_num2 <= in_num2;
                held_mode <= in_mode;
                held_tag  <= in_tag;
            end

            if (flush) begin
                res_valid <= 1'b0;
            end else if (capture) begin
                res_valid <= 1'b1;
                res_data  <= cap_data;
                res_err   <= cu_error;
                res_tag   <= cap_tag;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end

            // Only the first error since the last clear is kept.
            if (err_clr) begin
                err_sticky <= EW'(0);
            end else if (capture && (err_sticky == EW'(0)) && (cu_error != EW'(0))) begin
                err_sticky <= cu_error;
            end
        end
    end

endmodule
